// File: rtl/bf16_pkg.sv
// bf16_pkg: shared bfloat16 formats, limits and converter states
package bf16_pkg;
  typedef enum logic [2:0] {IDLE, DECODE, SHIFT, APPLY_SIGN, DONE} state_t;
  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int BF16_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
  localparam logic [15:0] INT16_MAX = 16'h7FFF;
  localparam logic [15:0] INT16_MIN = 16'h8000;
endpackage

// File: rtl/bf16_classify.sv
// bf16_classify: splits a bfloat16 word into fields and value class
module bf16_classify
  import bf16_pkg::*;
(
  input  logic [15:0]      a,
  output logic             sign,
  output logic [EXP_W-1:0] exponent,
  output logic [MAN_W-1:0] mantissa,
  output logic             is_zero,
  output logic             is_subnormal,
  output logic             is_inf,
  output logic             is_nan
);
  assign {sign, exponent, mantissa} = a;
  assign is_zero      = exponent == '0 && mantissa == '0;
  assign is_subnormal = exponent == '0 && mantissa != '0;
  assign is_inf       = exponent == EXP_SPECIAL && mantissa == '0;
  assign is_nan       = exponent == EXP_SPECIAL && mantissa != '0;
endmodule

// File: rtl/bfloat16_to_int16.sv
// bfloat16_to_int16: iterative truncating, saturating bfloat16 to int16 converter
module bfloat16_to_int16
  import bf16_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        overflow,
  output logic        nan,
  output logic        inexact
);
  state_t state, state_n;
  logic [15:0] a_r, mag;
  logic [3:0] cnt, n, kl;
  logic left;
  logic sign, is_zero, is_subnormal, is_inf, is_nan, special;
  logic [EXP_W-1:0] exponent;
  logic [MAN_W-1:0] mantissa;
  logic signed [8:0] k;
  logic [15:0] sat;

  bf16_classify u_classify (
    .a(a_r), .sign(sign), .exponent(exponent), .mantissa(mantissa),
    .is_zero(is_zero), .is_subnormal(is_subnormal), .is_inf(is_inf), .is_nan(is_nan)
  );

  assign k       = $signed({1'b0, exponent}) - $signed(9'(BF16_BIAS));
  assign kl      = k[3:0];
  assign n       = kl < 4'd7 ? 4'd7 - kl : kl - 4'd7;
  assign special = is_nan | is_inf | is_zero | is_subnormal | k < 9'sd0 | k > 9'sd14;
  assign sat     = sign ? INT16_MIN : INT16_MAX;

  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = in_valid ? DECODE : IDLE;
      DECODE:     state_n = special ? DONE : (n == 4'd0 ? APPLY_SIGN : SHIFT);
      SHIFT:      state_n = cnt == 4'd1 ? APPLY_SIGN : SHIFT;
      APPLY_SIGN: state_n = DONE;
      DONE:       state_n = out_ready ? IDLE : DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_r <= '0;
      mag <= '0;
      cnt <= '0;
      left <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      nan <= 1'b0;
      inexact <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (in_valid) begin
            a_r <= a;
            result <= '0;
            overflow <= 1'b0;
            nan <= 1'b0;
            inexact <= 1'b0;
          end
        DECODE: begin
          mag <= {8'b0, 1'b1, mantissa};
          cnt <= n;
          left <= k > 9'sd7;
          if (is_nan) nan <= 1'b1;
          else if (is_inf) {result, overflow} <= {sat, 1'b1};
          else if (is_zero | is_subnormal) inexact <= is_subnormal;
          else if (k < 9'sd0) inexact <= 1'b1;
          else if (k == 9'sd15 && sign && mantissa == '0) result <= INT16_MIN;
          else if (k > 9'sd14) {result, overflow} <= {sat, 1'b1};
        end
        SHIFT: begin
          mag <= left ? mag << 1 : mag >> 1;
          inexact <= inexact | (~left & mag[0]);
          cnt <= cnt - 4'd1;
        end
        APPLY_SIGN: result <= sign ? -mag : mag;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bfloat16_to_int16.sv
// tb_bfloat16_to_int16: directed-vector self-checking bench for the converter
module tb_bfloat16_to_int16;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [15:0] a = '0;
  logic in_ready, out_valid, overflow, nan, inexact;
  logic [15:0] result;
  int n_checks = 0, n_fail = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] r;
    logic [2:0]  f;
    logic [3:0]  lat;
  } vec_t;

  bfloat16_to_int16 dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .nan(nan), .inexact(inexact)
  );

  always #5 clock = ~clock;

  task automatic convert(input logic [15:0] v, output int lat);
    @(negedge clock);
    a = v;
    in_valid = 1;
    @(posedge clock);
    #1 in_valid = 0;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clock);
      #1 if (out_valid) lat = i;
    end
  endtask

  task automatic take();
    out_ready = 1;
    @(posedge clock);
    #1 out_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({in_ready, out_valid, result, overflow, nan, inexact} !== {2'b10, 16'h0000, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b vld=%b res=%h flags=%b%b%b, want rdy=1 vld=0 res=0000 flags=000",
               in_ready, out_valid, result, overflow, nan, inexact);
    end
    reset = 0;
  endtask

  task automatic test_normal();
    vec_t v [4] = '{'{16'h3F80, 16'h0001, 3'b000, 4'd9},
                    '{16'hC2F6, 16'hFF85, 3'b000, 4'd3},
                    '{16'h4030, 16'h0002, 3'b001, 4'd8},
                    '{16'h4300, 16'h0080, 3'b000, 4'd2}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      convert(v[i].a, lat);
      n_checks++;
      if (lat != int'(v[i].lat)) begin
        n_fail++;
        $display("FAIL normal latency a=%h: got %0d, want %0d", v[i].a, lat, v[i].lat);
      end
      n_checks++;
      if ({result, overflow, nan, inexact} !== {v[i].r, v[i].f}) begin
        n_fail++;
        $display("FAIL normal a=%h: got %h/%b%b%b, want %h/%b", v[i].a, result, overflow, nan, inexact, v[i].r, v[i].f);
      end
      take();
    end
  endtask

  task automatic test_saturate();
    vec_t v [3] = '{'{16'h4700, 16'h7FFF, 3'b100, 4'd1},
                    '{16'hC700, 16'h8000, 3'b000, 4'd1},
                    '{16'hFF80, 16'h8000, 3'b100, 4'd1}};
    int lat;
    for (int i = 0; i < 3; i++) begin
      convert(v[i].a, lat);
      n_checks++;
      if (lat != int'(v[i].lat) || {result, overflow, nan, inexact} !== {v[i].r, v[i].f}) begin
        n_fail++;
        $display("FAIL saturate a=%h: got %h/%b%b%b lat %0d, want %h/%b lat %0d",
                 v[i].a, result, overflow, nan, inexact, lat, v[i].r, v[i].f, v[i].lat);
      end
      take();
    end
  endtask

  task automatic test_special();
    vec_t v [4] = '{'{16'h7FC0, 16'h0000, 3'b010, 4'd1},
                    '{16'h3F00, 16'h0000, 3'b001, 4'd1},
                    '{16'h0001, 16'h0000, 3'b001, 4'd1},
                    '{16'h8000, 16'h0000, 3'b000, 4'd1}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      convert(v[i].a, lat);
      n_checks++;
      if (lat != int'(v[i].lat) || {result, overflow, nan, inexact} !== {v[i].r, v[i].f}) begin
        n_fail++;
        $display("FAIL special a=%h: got %h/%b%b%b lat %0d, want %h/%b lat %0d",
                 v[i].a, result, overflow, nan, inexact, lat, v[i].r, v[i].f, v[i].lat);
      end
      take();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    convert(16'hC2F6, lat);
    a = 16'h3F80;
    in_valid = 1;
    repeat (5) begin
      @(posedge clock);
      #1;
      n_checks++;
      if ({out_valid, in_ready, result, overflow, nan, inexact} !== {2'b10, 16'hFF85, 3'b000}) begin
        n_fail++;
        $display("FAIL backpressure hold: got vld=%b rdy=%b res=%h flags=%b%b%b, want vld=1 rdy=0 res=ff85 flags=000",
                 out_valid, in_ready, result, overflow, nan, inexact);
      end
    end
    out_ready = 1;
    @(posedge clock);
    #1 out_ready = 0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL handshake: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clock);
    #1 in_valid = 0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL next accept: got rdy=%b, want 0", in_ready);
    end
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clock);
      #1 if (out_valid) lat = i;
    end
    n_checks++;
    if (lat != 9 || result !== 16'h0001) begin
      n_fail++;
      $display("FAIL next operand: got %h lat %0d, want 0001 lat 9", result, lat);
    end
    take();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    @(negedge clock);
    a = 16'h3F80;
    in_valid = 1;
    @(posedge clock);
    #1 in_valid = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1;
    @(posedge clock);
    #1 reset = 0;
    n_checks++;
    if ({in_ready, out_valid, result, overflow, nan, inexact} !== {2'b10, 16'h0000, 3'b000}) begin
      n_fail++;
      $display("FAIL reset mid: got rdy=%b vld=%b res=%h flags=%b%b%b, want rdy=1 vld=0 res=0000 flags=000",
               in_ready, out_valid, result, overflow, nan, inexact);
    end
    repeat (12) begin
      @(posedge clock);
      #1 if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset mid stray out_valid: got %0d cycles, want 0", seen);
    end
    convert(16'h4300, lat);
    n_checks++;
    if (lat != 2 || {result, overflow, nan, inexact} !== {16'h0080, 3'b000}) begin
      n_fail++;
      $display("FAIL after reset: got %h/%b%b%b lat %0d, want 0080/000 lat 2", result, overflow, nan, inexact, lat);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_saturate();
    test_special();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
